smm_mul_arbiter: RTL and testbench

SMM_MUL_ARBITER -- requirements
Module: smm_mul_arbiter

---
 rtl/smm_mul_arbiter.sv | 114 +++++++++++
 tb/tb_smm_mul_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/smm_mul_arbiter.sv
// Round-robin arbiter sharing one registered 32x32->64 multiplier.
// Optional statistics counters enabled by SMM_MUL_ARB_STATS_EN.
module smm_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  mul_ce,
    output logic [31:0]           mul_din0,
    output logic [31:0]           mul_din1,
    input  logic [63:0]           mul_dout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [63:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic [31:0]           stat_issue_cnt,
    output logic [31:0]           stat_stall_cnt
);

    logic            r_vld;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] r_last;

    logic               w_adv;
    logic               w_gnt;
    logic [ID_W-1:0]    w_gid;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_rr;
    logic [31:0]        w_din0;
    logic [31:0]        w_din1;

    assign w_adv = !r_vld || res_ready;

    // Lowest k wins, so the search starts just after the last grant.
    always_comb begin
        w_gnt = 1'b0;
        w_gid = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_last) + 1 + k) % NUM_REQ);
            if (w_adv && !reset && req_valid[w_idx]) begin
                w_gnt = 1'b1;
                w_gid = w_idx;
            end
        end
    end

    always_comb begin
        w_rr   = '0;
        w_din0 = '0;
        w_din1 = '0;
        if (w_gnt) begin
            w_rr[w_gid] = 1'b1;
            w_din0      = req_a[32*int'(w_gid) +: 32];
            w_din1      = req_b[32*int'(w_gid) +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= 1'b0;
            r_id   <= '0;
            r_last <= ID_W'(NUM_REQ - 1);
        end else begin
            if (w_adv) begin
                r_vld <= w_gnt;
                r_id  <= w_gid;
            end
            if (w_gnt) begin
                r_last <= w_gid;
            end
        end
    end

    // Reset forces the enable so the external register is flushed.
    assign mul_ce    = w_adv || reset;
    assign mul_din0  = w_din0;
    assign mul_din1  = w_din1;
    assign req_ready = w_rr;
    assign res_valid = r_vld;
    assign res_id    = r_id;
    assign res_data  = mul_dout;

`ifdef SMM_MUL_ARB_STATS_EN
    logic [31:0] r_issue;
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue <= '0;
            r_stall <= '0;
        end else begin
            if (w_gnt) begin
                r_issue <= r_issue + 32'd1;
            end
            if (r_vld && !res_ready) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign stat_issue_cnt = r_issue;
    assign stat_stall_cnt = r_stall;
`else
    assign stat_issue_cnt = 32'd0;
    assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_smm_mul_arbiter.sv
// Scoreboard bench for smm_mul_arbiter with a behavioural multiplier.
// Directed vectors cover contention, back-pressure, sparse and reset.
module tb_smm_mul_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         mul_ce;
    logic [31:0]  mul_din0;
    logic [31:0]  mul_din1;
    logic [63:0]  mul_dout = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [63:0]  res_data;
    logic [1:0]   res_id;
    logic [31:0]  stat_issue_cnt;
    logic [31:0]  stat_stall_cnt;

    logic [31:0] opa[4];
    logic [31:0] opb[4];
    logic [31:0] na[4];
    logic [31:0] nb[4];

    typedef struct {
        int          id;
        logic [63:0] p;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;
    int exp_issue = 0;
    int exp_stall = 0;

    smm_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
        .stat_issue_cnt(stat_issue_cnt),
        .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
        end
    end

    always @(posedge clk) begin
        if (mul_ce) mul_dout <= 64'(mul_din0) * 64'(mul_din1);
    end

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 64'(res_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_id", 64'(res_id), 64'(e.id));
                chk("res_data", res_data, e.p);
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] v,
                        input logic rdy, input int eg,
                        input logic ece, input logic erv);
        logic [3:0] err;
        @(posedge clk);
        #1;
        reset = rst;
        req_valid = v;
        res_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            opa[i] = na[i];
            opb[i] = nb[i];
        end
        @(negedge clk);
        err = '0;
        if (eg >= 0) err[eg] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(err));
        chk("mul_ce", 64'(mul_ce), 64'(ece));
        chk("res_valid", 64'(res_valid), 64'(erv));
`ifdef SMM_MUL_ARB_STATS_EN
        chk("stat_issue", 64'(stat_issue_cnt), 64'(exp_issue));
        chk("stat_stall", 64'(stat_stall_cnt), 64'(exp_stall));
`else
        chk("stat_issue", 64'(stat_issue_cnt), 64'd0);
        chk("stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
        if (eg >= 0) begin
            q.push_back('{eg, 64'(opa[eg]) * 64'(opb[eg])});
            exp_issue++;
        end
        if (erv && !rdy) exp_stall++;
        if (rst) begin
            q.delete();
            exp_issue = 0;
            exp_stall = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            na[i] = '0;
            nb[i] = '0;
            opa[i] = '0;
            opb[i] = '0;
        end
        step(1, 4'b1111, 1, -1, 1, 0);
        step(1, 4'b1111, 1, -1, 1, 0);

        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) begin
                na[i] = 32'(c * 4 + i + 1);
                nb[i] = 32'(i * 10 + c + 7);
            end
            step(0, 4'b1111, 1, c % 4, 1, c != 0);
        end

        na[0] = 32'd3;
        nb[0] = 32'd5;
        step(0, 4'b0001, 1, 0, 1, 1);
        na[0] = 32'hFFFF_FFFF;
        nb[0] = 32'hFFFF_FFFF;
        step(0, 4'b0001, 1, 0, 1, 1);
        chk("single_15", res_data, 64'd15);

        na[2] = 32'd7;
        nb[2] = 32'd6;
        step(0, 4'b0100, 1, 2, 1, 1);
        chk("max_width", res_data, 64'hFFFF_FFFE_0000_0001);

        for (int s = 0; s < 3; s++) begin
            step(0, 4'b1111, 0, -1, 0, 1);
            chk("stall_id", 64'(res_id), 64'd2);
            chk("stall_data", res_data, 64'd42);
        end
        step(0, 4'b0000, 1, -1, 1, 1);

        na[1] = 32'd11;
        nb[1] = 32'd13;
        na[3] = 32'h8000_0000;
        nb[3] = 32'd4;
        step(0, 4'b1000, 1, 3, 1, 0);
        step(0, 4'b1010, 1, 1, 1, 1);
        step(0, 4'b1010, 1, 3, 1, 1);
        step(0, 4'b1010, 1, 1, 1, 1);
        step(0, 4'b0000, 1, -1, 1, 1);

        na[2] = 32'd9;
        nb[2] = 32'd9;
        step(0, 4'b0100, 1, 2, 1, 0);
        step(0, 4'b1111, 0, -1, 0, 1);
        step(1, 4'b1111, 0, -1, 1, 1);
        step(1, 4'b1111, 0, -1, 1, 0);
        na[0] = 32'd100;
        nb[0] = 32'd3;
        step(0, 4'b1111, 1, 0, 1, 0);
        step(0, 4'b0000, 1, -1, 1, 1);
        step(0, 4'b0000, 1, -1, 1, 0);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
